sent_slow_msg_sched: RTL and testbench
======================================

# sent_slow_msg_sched

Slow-channel message scheduler for the SENT transmitter. It holds up to four pending serial (short or enhanced) slow-channel messages written by the host. Round-robin arbitration picks one and presents its ID, data and format to the SENT TX control block. It then counts transmitted fast frames until the 16-frame (short serial) or 18-frame (enhanced serial) message completes, retires the slot and moves to the next requester.

## Interface
Parameters:
- NUM_SLOTS, 4: number of message slots. Fixed at 4; slot index is 2 bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  host write strobe, one cycle.
- wr_slot  in  2  target slot.
- wr_id  in  8  message ID. Short format uses wr_id[3:0].
- wr_data  in  16  message data. Short format uses [7:0]; enhanced with config=0 uses [11:0].
- wr_enhanced  in  1  0 = short serial (16 frames), 1 = enhanced serial (18 frames).
- wr_config  in  1  enhanced configuration bit.
- wr_err  out  1  one-cycle pulse; write rejected because the slot is active.
- slot_pending  out  4  per-slot pending flags.
- frame_done  in  1  one-cycle pulse from TX control at the end of each frame (CRC or pause complete).
- abort  in  1  level; cancels the active message.
- tx_enable  out  1  enable to TX control; equals msg_valid.
- msg_valid  out  1  msg_* outputs are valid and a message is in transmission.
- msg_slot  out  2  slot being transmitted.
- msg_id  out  8  latched ID.
- msg_data  out  16  latched data.
- msg_enhanced  out  1  latched format.
- msg_config  out  1  latched config bit.
- msg_done  out  1  one-cycle pulse; message fully transmitted.

## Operation
- **Storage:** per slot, registered id/data/enhanced/config fields plus a pending bit.
- **Writes:**
  - wr_en to a non-active slot stores all fields and sets pending (overwrites if already pending).
  - The active slot is msg_slot while the FSM is in ARB or RUN. A write to it is ignored, and wr_err pulses the next cycle.
- **Arbitration:** round-robin. Search starts at rr_ptr, checks rr_ptr, rr_ptr+1, … mod 4, and takes the first pending slot. rr_ptr resets to 0.
- **FSM states:**
  - IDLE: if any pending bit is set, go to ARB.
  - ARB: latch the selected slot fields into msg_*, set msg_valid=1, clear frame_cnt (5 bits), go to RUN.
  - RUN: frame_done increments frame_cnt. A frame_done with frame_cnt==15 (short) or 17 (enhanced) goes to DONE. An abort has priority over frame_done: clear msg_valid, go to IDLE; slot stays pending and rr_ptr is unchanged, so the same slot retries.
  - DONE: msg_done=1, msg_valid=0. At the exiting edge, clear pending[msg_slot] and set rr_ptr=msg_slot+1 (wraps 3→0). Go to IDLE.
- **Write during DONE:** a wr_en to msg_slot in DONE is accepted. The set wins over the clear, so the slot stays pending with the new data.
- **frame_done outside RUN** is ignored.
- **Stability:** msg_* fields hold stable throughout RUN. Later writes never change an in-flight message.
- **Reset values:** all outputs 0. Pending bits, stored fields, rr_ptr and frame_cnt are 0. State is IDLE.
- **Reset mid-message:** reset dominates; everything returns to reset values the next cycle and all pending messages are lost.

## Timing
- All outputs are registered.
- **Write to msg_valid:** wr_en in cycle 0 → pending visible cycle 1 → ARB cycle 2 → msg_valid high cycle 3.
- **Completion:** the final frame_done in cycle k gives msg_done=1 and msg_valid=0 in cycle k+1, IDLE in k+2 and ARB in k+3. When another slot is pending, the next msg_valid rises in k+4.
- **Abort:** abort in cycle k drops msg_valid in cycle k+1.
- **Error pulse:** wr_err rises one cycle after the rejected wr_en.
- **Counting:** frame_done pulses may arrive back-to-back; each is counted.

## Test plan
- Reset, then write slot 2 (id=0x5, data=0x0A3, short) → msg_valid rises 3 cycles later with msg_slot=2, msg_id=0x05, msg_data=0x00A3. After 16 frame_done pulses, msg_done pulses once and slot_pending=0000.
- Enhanced write to slot 1 (id=0x7C, data=0x0FFF, config=0) → 17 frame_done pulses leave msg_valid high; the 18th gives msg_done.
- Slots 0, 1 and 3 pending → service order 0, 1, 3. Rewrite slot 0 during slot 1's transmission → order continues 3, then 0 with the new data.
- Write to the active slot during RUN → wr_err pulses and msg_data is unchanged. Write to the same slot during DONE → the slot is re-served with the new data.
- Abort after 5 frames on slot 2 → msg_valid drops next cycle, slot_pending[2] stays 1, and the message restarts with frame_cnt=0.
- Reset asserted mid-RUN → next cycle all outputs 0, slot_pending=0000, and frame_done pulses are ignored.

Source files
------------

// File: rtl/sent_slow_msg_sched.sv
// SENT slow-channel message scheduler: four host-written message slots served
// round-robin, each held stable on msg_* until its 16 or 18 fast frames complete.
module sent_slow_msg_sched #(
  parameter int NUM_SLOTS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr_en,
  input  logic [1:0]           i_wr_slot,
  input  logic [7:0]           i_wr_id,
  input  logic [15:0]          i_wr_data,
  input  logic                 i_wr_enhanced,
  input  logic                 i_wr_config,
  output logic                 o_wr_err,
  output logic [NUM_SLOTS-1:0] o_slot_pending,
  input  logic                 i_frame_done,
  input  logic                 i_abort,
  output logic                 o_tx_enable,
  output logic                 o_msg_valid,
  output logic [1:0]           o_msg_slot,
  output logic [7:0]           o_msg_id,
  output logic [15:0]          o_msg_data,
  output logic                 o_msg_enhanced,
  output logic                 o_msg_config,
  output logic                 o_msg_done
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_RUN, S_DONE} state_t;

  state_t               r_state;
  logic [7:0]           r_id   [NUM_SLOTS];
  logic [15:0]          r_data [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_enh;
  logic [NUM_SLOTS-1:0] r_cfg;
  logic [NUM_SLOTS-1:0] r_pending;
  logic [1:0]           r_rr_ptr;
  logic [4:0]           r_frame_cnt;
  logic                 r_wr_err;
  logic                 r_msg_valid;
  logic [1:0]           r_msg_slot;
  logic [7:0]           r_msg_id;
  logic [15:0]          r_msg_data;
  logic                 r_msg_enhanced;
  logic                 r_msg_config;
  logic                 r_msg_done;

  logic                 w_wr_reject;
  logic [NUM_SLOTS-1:0] w_wr_hit;
  logic                 w_any;
  logic [1:0]           w_sel;
  logic [1:0]           w_idx;
  logic                 w_found;
  logic [4:0]           w_last;

  // The slot is locked from selection until DONE; in DONE a rewrite is allowed.
  assign w_wr_reject = i_wr_en && (r_state == S_ARB || r_state == S_RUN) &&
                       (i_wr_slot == r_msg_slot);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_hit
      assign w_wr_hit[gi] = i_wr_en && !w_wr_reject && (i_wr_slot == 2'(gi));
    end
  endgenerate

  assign w_any  = |r_pending;
  assign w_last = r_msg_enhanced ? 5'd17 : 5'd15;

  always_comb begin
    w_sel   = r_rr_ptr;
    w_idx   = r_rr_ptr;
    w_found = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      w_idx = r_rr_ptr + 2'(k);
      if (!w_found && r_pending[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (i_reset) begin
        r_id[s]      <= '0;
        r_data[s]    <= '0;
        r_enh[s]     <= 1'b0;
        r_cfg[s]     <= 1'b0;
        r_pending[s] <= 1'b0;
      end else if (w_wr_hit[s]) begin
        r_id[s]      <= i_wr_id;
        r_data[s]    <= i_wr_data;
        r_enh[s]     <= i_wr_enhanced;
        r_cfg[s]     <= i_wr_config;
        r_pending[s] <= 1'b1;
      end else if (r_state == S_DONE && r_msg_slot == 2'(s)) begin
        r_pending[s] <= 1'b0;
      end
    end
  end

  // msg_slot is chosen on the IDLE->ARB edge so the locked slot is known in ARB.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_frame_cnt    <= '0;
      r_wr_err       <= 1'b0;
      r_msg_valid    <= 1'b0;
      r_msg_slot     <= '0;
      r_msg_id       <= '0;
      r_msg_data     <= '0;
      r_msg_enhanced <= 1'b0;
      r_msg_config   <= 1'b0;
      r_msg_done     <= 1'b0;
    end else begin
      r_wr_err   <= w_wr_reject;
      r_msg_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_msg_slot <= w_sel;
            r_state    <= S_ARB;
          end
        end
        S_ARB: begin
          r_msg_id       <= r_id[r_msg_slot];
          r_msg_data     <= r_data[r_msg_slot];
          r_msg_enhanced <= r_enh[r_msg_slot];
          r_msg_config   <= r_cfg[r_msg_slot];
          r_msg_valid    <= 1'b1;
          r_frame_cnt    <= '0;
          r_state        <= S_RUN;
        end
        S_RUN: begin
          if (i_abort) begin
            r_msg_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else if (i_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 5'd1;
            if (r_frame_cnt == w_last) begin
              r_msg_valid <= 1'b0;
              r_msg_done  <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_rr_ptr <= r_msg_slot + 2'd1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_wr_err       = r_wr_err;
  assign o_slot_pending = r_pending;
  assign o_tx_enable    = r_msg_valid;
  assign o_msg_valid    = r_msg_valid;
  assign o_msg_slot     = r_msg_slot;
  assign o_msg_id       = r_msg_id;
  assign o_msg_data     = r_msg_data;
  assign o_msg_enhanced = r_msg_enhanced;
  assign o_msg_config   = r_msg_config;
  assign o_msg_done     = r_msg_done;

endmodule

// File: tb/tb_sent_slow_msg_sched.sv
// Bench for sent_slow_msg_sched: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a message-level model.
module tb_sent_slow_msg_sched;

  logic        clk = 1'b0;
  logic        reset, wr_en, wr_enhanced, wr_config, frame_done, abort;
  logic [1:0]  wr_slot;
  logic [7:0]  wr_id;
  logic [15:0] wr_data;
  wire         wr_err, tx_enable, msg_valid, msg_enhanced, msg_config, msg_done;
  wire  [3:0]  slot_pending;
  wire  [1:0]  msg_slot;
  wire  [7:0]  msg_id;
  wire  [15:0] msg_data;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  sent_slow_msg_sched dut (
    .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en), .i_wr_slot(wr_slot),
    .i_wr_id(wr_id), .i_wr_data(wr_data), .i_wr_enhanced(wr_enhanced),
    .i_wr_config(wr_config), .o_wr_err(wr_err), .o_slot_pending(slot_pending),
    .i_frame_done(frame_done), .i_abort(abort), .o_tx_enable(tx_enable),
    .o_msg_valid(msg_valid), .o_msg_slot(msg_slot), .o_msg_id(msg_id),
    .o_msg_data(msg_data), .o_msg_enhanced(msg_enhanced),
    .o_msg_config(msg_config), .o_msg_done(msg_done)
  );

  // Model: stored slots plus one in-flight message with a frames-left countdown.
  // stage 0 = waiting, 1 = slot chosen (loading), 2 = transmitting, 3 = completion.
  bit [7:0]  f_id   [4];
  bit [15:0] f_data [4];
  bit        f_enh  [4];
  bit        f_cfg  [4];
  bit [3:0]  pend = '0;
  int        rr = 0, m_stage = 0, m_slot = 0, m_left = 0;
  bit        m_valid = 0, m_done = 0, m_err = 0, m_enh = 0, m_cfg = 0;
  bit [7:0]  m_id = '0;
  bit [15:0] m_data = '0;

  function automatic int pick();
    for (int k = 0; k < 4; k++)
      if (pend[(rr + k) % 4]) return (rr + k) % 4;
    return 0;
  endfunction

  task automatic model_step();
    int  act;
    bit  err_n;
    if (reset) begin
      for (int s = 0; s < 4; s++) begin
        f_id[s] = '0; f_data[s] = '0; f_enh[s] = 0; f_cfg[s] = 0;
      end
      pend = '0; rr = 0; m_stage = 0; m_slot = 0; m_left = 0;
      m_valid = 0; m_done = 0; m_err = 0; m_enh = 0; m_cfg = 0;
      m_id = '0; m_data = '0;
      return;
    end
    act   = (m_stage == 1 || m_stage == 2) ? m_slot : -1;
    err_n = wr_en && (int'(wr_slot) == act);
    case (m_stage)
      0: if (pend != 0) begin m_slot = pick(); m_stage = 1; end
      1: begin
        m_id = f_id[m_slot]; m_data = f_data[m_slot];
        m_enh = f_enh[m_slot]; m_cfg = f_cfg[m_slot];
        m_valid = 1; m_left = m_enh ? 18 : 16; m_stage = 2;
      end
      2: begin
        if (abort) begin
          m_valid = 0; m_stage = 0;
        end else if (frame_done) begin
          m_left--;
          if (m_left == 0) begin m_valid = 0; m_done = 1; m_stage = 3; end
        end
      end
      default: begin
        m_done = 0; pend[m_slot] = 0; rr = (m_slot + 1) % 4; m_stage = 0;
      end
    endcase
    if (wr_en && !err_n) begin
      f_id[wr_slot] = wr_id; f_data[wr_slot] = wr_data;
      f_enh[wr_slot] = wr_enhanced; f_cfg[wr_slot] = wr_config;
      pend[wr_slot] = 1;
    end
    m_err = err_n;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("wr_err", 32'(wr_err), 32'(m_err));
    check("slot_pending", 32'(slot_pending), 32'(pend));
    check("tx_enable", 32'(tx_enable), 32'(m_valid));
    check("msg_valid", 32'(msg_valid), 32'(m_valid));
    check("msg_slot", 32'(msg_slot), 32'(m_slot));
    check("msg_id", 32'(msg_id), 32'(m_id));
    check("msg_data", 32'(msg_data), 32'(m_data));
    check("msg_enhanced", 32'(msg_enhanced), 32'(m_enh));
    check("msg_config", 32'(msg_config), 32'(m_cfg));
    check("msg_done", 32'(msg_done), 32'(m_done));
    if (m_done)
      $display("msg done slot=%0d id=%02h data=%04h enh=%0d", m_slot, m_id, m_data, m_enh);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (cmp_en) compare();
  end

  task automatic wr(input int s, input logic [7:0] id, input logic [15:0] d,
                    input bit enh, input bit cfg);
    wr_en = 1; wr_slot = 2'(s); wr_id = id; wr_data = d;
    wr_enhanced = enh; wr_config = cfg;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic run_msg(input int n);
    for (int i = 0; i < n; i++) begin
      frame_done = 1;
      @(negedge clk);
    end
    frame_done = 0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40 && msg_valid !== 1'b1; i++) @(negedge clk);
    if (msg_valid !== 1'b1) begin
      total++; bad++;
      $display("FAIL wait_valid: got=timeout want=msg_valid t=%0t", $time);
    end
  endtask

  task automatic serve(input int s, input logic [15:0] d);
    wait_valid();
    check("serve_slot", 32'(msg_slot), 32'(s));
    check("serve_data", 32'(msg_data), 32'(d));
  endtask

  initial begin
    reset = 1; wr_en = 0; wr_slot = 0; wr_id = 0; wr_data = 0;
    wr_enhanced = 0; wr_config = 0; frame_done = 0; abort = 0;
    @(negedge clk);
    cmp_en = 1;
    @(negedge clk);
    check("rst_valid", 32'(msg_valid), 0);
    check("rst_pending", 32'(slot_pending), 0);
    check("rst_data", 32'(msg_data), 0);
    reset = 0;

    // Short message on slot 2: valid three cycles after the write.
    wr(2, 8'h05, 16'h00A3, 0, 0);
    check("t1_pending", 32'(slot_pending), 32'h4);
    @(negedge clk);
    check("t1_valid_early", 32'(msg_valid), 0);
    @(negedge clk);
    check("t1_valid", 32'(msg_valid), 1);
    check("t1_slot", 32'(msg_slot), 2);
    check("t1_id", 32'(msg_id), 32'h05);
    check("t1_data", 32'(msg_data), 32'h00A3);
    run_msg(15);
    check("t1_valid_15", 32'(msg_valid), 1);
    run_msg(1);
    check("t1_done", 32'(msg_done), 1);
    check("t1_valid_off", 32'(msg_valid), 0);
    @(negedge clk);
    check("t1_done_pulse", 32'(msg_done), 0);
    check("t1_pending_clr", 32'(slot_pending), 0);

    // Enhanced message: 18 frames.
    wr(1, 8'h7C, 16'h0FFF, 1, 0);
    wait_valid();
    check("t2_id", 32'(msg_id), 32'h7C);
    check("t2_enh", 32'(msg_enhanced), 1);
    run_msg(17);
    check("t2_valid_17", 32'(msg_valid), 1);
    check("t2_done_17", 32'(msg_done), 0);
    run_msg(1);
    check("t2_done", 32'(msg_done), 1);
    @(negedge clk);

    // Round-robin order, rewrite of a waiting slot, rejected write, DONE rewrite.
    wr(0, 8'h11, 16'h0100, 0, 0);
    wr(1, 8'h22, 16'h0200, 0, 0);
    wr(3, 8'h33, 16'h0300, 0, 1);
    serve(0, 16'h0100);
    run_msg(16);
    serve(1, 16'h0200);
    wr(0, 8'h44, 16'hBEEF, 0, 0);
    wr(1, 8'h55, 16'hDEAD, 0, 0);
    check("t3_wr_err", 32'(wr_err), 1);
    check("t3_data_hold", 32'(msg_data), 32'h0200);
    run_msg(16);
    serve(3, 16'h0300);
    run_msg(16);
    serve(0, 16'hBEEF);
    run_msg(16);
    wr(0, 8'h66, 16'h1234, 0, 0);
    check("t3_done_wr_pend", 32'(slot_pending), 32'h1);
    serve(0, 16'h1234);
    run_msg(16);
    @(negedge clk);

    // Abort after 5 frames: slot stays pending and restarts from frame 0.
    wr(2, 8'h09, 16'h0055, 0, 0);
    wait_valid();
    run_msg(5);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("t4_valid_drop", 32'(msg_valid), 0);
    check("t4_pending", 32'(slot_pending[2]), 1);
    wait_valid();
    check("t4_retry_slot", 32'(msg_slot), 2);
    run_msg(15);
    check("t4_valid_15", 32'(msg_valid), 1);
    run_msg(1);
    check("t4_done", 32'(msg_done), 1);
    @(negedge clk);

    // Reset in the middle of a message.
    wr(0, 8'hA1, 16'h0A0A, 0, 0);
    wr(3, 8'hA3, 16'h0B0B, 1, 1);
    wait_valid();
    run_msg(3);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("t5_valid", 32'(msg_valid), 0);
    check("t5_pending", 32'(slot_pending), 0);
    check("t5_id", 32'(msg_id), 0);
    run_msg(4);
    check("t5_idle_valid", 32'(msg_valid), 0);
    check("t5_idle_done", 32'(msg_done), 0);

    // Random traffic against the model.
    repeat (4000) begin
      reset       = ($urandom_range(999) == 0);
      wr_en       = ($urandom_range(7) == 0);
      wr_slot     = 2'($urandom_range(3));
      wr_id       = 8'($urandom);
      wr_data     = 16'($urandom);
      wr_enhanced = 1'($urandom_range(1));
      wr_config   = 1'($urandom_range(1));
      frame_done  = ($urandom_range(2) != 0);
      abort       = ($urandom_range(63) == 0);
      @(negedge clk);
    end
    reset = 0; wr_en = 0; frame_done = 0; abort = 0;
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
